// File: rtl/iitk_mini_mips_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_pkg
// Description : Shared encodings for the iitk_mini_mips multiply/divide unit:
//               operation codes, FSM states and small op-decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = $clog2(MDU_WIDTH);

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } mdu_state_e;

    // Bit 1 of the op code selects divide, bit 0 selects the unsigned flavour.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/iitk_mini_mips_mdu_if.sv
`default_nettype none
// ============================================================================
// Module      : iitk_mini_mips_mdu_if
// Description : Request/result bundle between the execute stage and the MDU.
// Revision    : 1.0 - initial release
// ============================================================================
interface iitk_mini_mips_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_val, rt_val, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, cancel,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/iitk_mini_mips_mdu_cond_neg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_cond_neg
// Description : Conditional two's-complement negation (dout = neg ? -din : din).
//               Used for operand magnitude and for final result sign fix-up.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_cond_neg #(
    parameter int W = 32
) (
    input  wire logic         neg,
    input  wire logic [W-1:0] din,
    output logic      [W-1:0] dout
);

    assign dout = neg ? -din : din;

endmodule
`default_nettype wire

// File: rtl/iitk_mini_mips_mdu.sv
`default_nettype none
// ============================================================================
// Module      : iitk_mini_mips_mdu
// Description : Iterative multiply/divide unit producing HI/LO. Shift-add
//               multiply and restoring divide, one bit per cycle, with sign
//               handling done by magnitude conversion before and after.
// Revision    : 1.0 - initial release
// ============================================================================
module iitk_mini_mips_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  wire logic              clk,
    input  wire logic              reset,
    iitk_mini_mips_mdu_if.slave    bus
);

    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mdu_state_e           r_state;
    mdu_state_e           w_state_nxt;
    logic                 w_busy;
    logic                 w_done;

    logic [1:0]           r_op;
    logic [2*WIDTH-1:0]   r_acc;    // multiply: {partial, multiplier}; divide: {remainder, quotient}
    logic [WIDTH-1:0]     r_opnd;   // multiplicand or divisor
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_sign_q; // sign of product / quotient
    logic                 r_sign_r; // sign of remainder (dividend's sign)
    logic                 r_div0;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_is_div;
    logic                 w_is_signed;
    logic                 w_accept;
    logic                 w_sign_rs;
    logic                 w_sign_rt;
    logic [WIDTH-1:0]     w_abs_acc;
    logic [WIDTH-1:0]     w_abs_opnd;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_nxt;
    logic [WIDTH:0]       w_div_trial;
    logic [WIDTH:0]       w_div_diff;
    logic                 w_div_ge;
    logic [2*WIDTH-1:0]   w_div_nxt;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

    assign w_is_div    = op_is_div(r_op);
    assign w_is_signed = op_is_signed(r_op);
    assign w_accept    = (r_state == S_IDLE) && bus.start && !bus.cancel;

    // For multiply rs sits in r_opnd and rt in the low accumulator half;
    // for divide the roles are swapped (dividend shifts through r_acc).
    assign w_sign_rs = w_is_signed & (w_is_div ? r_acc[WIDTH-1] : r_opnd[WIDTH-1]);
    assign w_sign_rt = w_is_signed & (w_is_div ? r_opnd[WIDTH-1] : r_acc[WIDTH-1]);

    mdu_cond_neg #(.W(WIDTH)) u_abs_acc (
        .neg  (w_is_signed & r_acc[WIDTH-1]),
        .din  (r_acc[WIDTH-1:0]),
        .dout (w_abs_acc)
    );

    mdu_cond_neg #(.W(WIDTH)) u_abs_opnd (
        .neg  (w_is_signed & r_opnd[WIDTH-1]),
        .din  (r_opnd),
        .dout (w_abs_opnd)
    );

    // Shift-add step: add multiplicand when the current multiplier bit is set, then shift right.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Restoring step: shift in next dividend bit, subtract divisor if it fits.
    assign w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_diff  = w_div_trial - {1'b0, r_opnd};
    assign w_div_ge    = (w_div_trial >= {1'b0, r_opnd});
    assign w_div_nxt   = w_div_ge ? {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1}
                                  : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    mdu_cond_neg #(.W(2*WIDTH)) u_fix_prod (
        .neg  (r_sign_q),
        .din  (r_acc),
        .dout (w_prod_fix)
    );

    mdu_cond_neg #(.W(WIDTH)) u_fix_quo (
        .neg  (r_sign_q),
        .din  (r_acc[WIDTH-1:0]),
        .dout (w_quo_fix)
    );

    mdu_cond_neg #(.W(WIDTH)) u_fix_rem (
        .neg  (r_sign_r),
        .din  (r_acc[2*WIDTH-1:WIDTH]),
        .dout (w_rem_fix)
    );

    // Divide by zero naturally leaves |rs| as remainder (re-signed to rs); only
    // the quotient needs forcing to all ones regardless of sign.
    assign w_res_hi = w_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_res_lo = w_is_div ? (r_div0 ? {WIDTH{1'b1}} : w_quo_fix) : w_prod_fix[WIDTH-1:0];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status outputs; cancel overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: if (bus.start) w_state_nxt = S_PREP;
            S_PREP: begin
                w_busy      = 1'b1;
                w_state_nxt = S_CALC;
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (r_cnt == '0) w_state_nxt = S_FIX;
            end
            S_FIX: begin
                w_busy      = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.cancel) w_state_nxt = S_IDLE;
    end

    // Datapath: latch, take magnitudes, iterate, then publish the signed result to hi/lo.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op     <= '0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_cnt    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_div0   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= bus.op;
                        r_acc  <= {{WIDTH{1'b0}}, (op_is_div(bus.op) ? bus.rs_val : bus.rt_val)};
                        r_opnd <= op_is_div(bus.op) ? bus.rt_val : bus.rs_val;
                    end
                end
                S_PREP: begin
                    r_acc    <= {{WIDTH{1'b0}}, w_abs_acc};
                    r_opnd   <= w_abs_opnd;
                    r_sign_q <= w_sign_rs ^ w_sign_rt;
                    r_sign_r <= w_sign_rs;
                    r_div0   <= w_is_div && (r_opnd == '0);
                    r_cnt    <= c_CNT_W'(WIDTH - 1);
                end
                S_CALC: begin
                    r_acc <= w_is_div ? w_div_nxt : w_mul_nxt;
                    if (r_cnt != '0) r_cnt <= r_cnt - c_CNT_W'(1);
                end
                S_FIX: begin
                    if (!bus.cancel) begin
                        r_hi <= w_res_hi;
                        r_lo <= w_res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_iitk_mini_mips_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_iitk_mini_mips_mdu
// Description : Directed self-checking bench for the iterative MDU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iitk_mini_mips_mdu;

    localparam int WIDTH   = 32;
    localparam int LAT_EXP = WIDTH + 3;   // start cycle to done cycle
    localparam int TMO     = 100;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    iitk_mini_mips_mdu_if #(.WIDTH(WIDTH)) bus ();

    iitk_mini_mips_mdu #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation and wait for done; operands are scrambled right after the start cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rhi, output logic [31:0] rlo, output int lat);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.op     = ~op;
        bus.rs_val = 32'hDEAD_BEEF;
        bus.rt_val = 32'h1357_9BDF;
        lat = 1;
        while (bus.done !== 1'b1 && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        rhi = bus.hi;
        rlo = bus.lo;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL reset_hi: got %h expected 00000000", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL reset_lo: got %h expected 00000000", bus.lo); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Latency, busy framing and single-cycle done on MULTU 7 x 6.
    task automatic test_latency();
        logic [31:0] h, l;
        int lat;
        run_op(2'b01, 32'd7, 32'd6, h, l, lat);
        checks++; if (lat !== LAT_EXP) begin failures++; $display("FAIL latency: got %0d expected %0d", lat, LAT_EXP); end
        checks++; if (h !== 32'h0) begin failures++; $display("FAIL multu7x6_hi: got %h expected 00000000", h); end
        checks++; if (l !== 32'h2A) begin failures++; $display("FAIL multu7x6_lo: got %h expected 0000002a", l); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_in_done: got %b expected 1", bus.busy); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL done_pulse_width: got %b expected 0", bus.done); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_after_done: got %b expected 0", bus.busy); end
    endtask

    // Arithmetic vectors, issued back to back (each start in the cycle after the previous done).
    task automatic test_arith();
        vec_t v[10];
        logic [31:0] h, l;
        int lat;
        v[0] = '{2'b00, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1};
        v[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
        v[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0000_0000};
        v[3] = '{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
        v[4] = '{2'b11, 32'd100,       32'd7,          32'd2,         32'd14};
        v[5] = '{2'b10, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD};
        v[6] = '{2'b11, 32'h0000_1234, 32'd0,          32'h0000_1234, 32'hFFFF_FFFF};
        v[7] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000};
        v[8] = '{2'b10, 32'hFFFF_FFF0, 32'd0,          32'hFFFF_FFF0, 32'hFFFF_FFFF};
        v[9] = '{2'b01, 32'd3,         32'd3,          32'd0,         32'd9};
        for (int i = 0; i < 10; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, h, l, lat);
            checks++; if (h !== v[i].eh) begin failures++; $display("FAIL arith_hi[%0d]: got %h expected %h", i, h, v[i].eh); end
            checks++; if (l !== v[i].el) begin failures++; $display("FAIL arith_lo[%0d]: got %h expected %h", i, l, v[i].el); end
            checks++; if (lat !== LAT_EXP) begin failures++; $display("FAIL arith_lat[%0d]: got %0d expected %0d", i, lat, LAT_EXP); end
        end
    endtask

    // A second start while busy must not queue or restart the operation.
    task automatic test_start_while_busy();
        int ndone = 0;
        logic [31:0] l = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.rs_val = 32'd2; bus.rt_val = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.start = 1'b1; bus.rs_val = 32'd100; bus.rt_val = 32'd100;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                ndone++;
                l = bus.lo;
            end
        end
        checks++; if (ndone !== 1) begin failures++; $display("FAIL busy_start_dones: got %0d expected 1", ndone); end
        checks++; if (l !== 32'd6) begin failures++; $display("FAIL busy_start_lo: got %h expected 00000006", l); end
    endtask

    // Cancel mid-CALC and cancel-beats-start in IDLE.
    task automatic test_cancel();
        logic [31:0] h, l;
        int lat;
        int ndone = 0;
        run_op(2'b01, 32'd11, 32'd13, h, l, lat);
        checks++; if (l !== 32'd143) begin failures++; $display("FAIL cancel_pre_lo: got %h expected 0000008f", l); end
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.rs_val = 32'd5; bus.rt_val = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);   // now in CALC cycle 10
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL cancel_busy: got %b expected 0", bus.busy); end
        bus.start = 1'b1; bus.cancel = 1'b1; bus.rs_val = 32'd4; bus.rt_val = 32'd4;
        @(negedge clk);
        bus.start = 1'b0; bus.cancel = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL cancel_over_start: got busy %b expected 0", bus.busy); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) ndone++;
        end
        checks++; if (ndone !== 0) begin failures++; $display("FAIL cancel_no_done: got %0d dones expected 0", ndone); end
        checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL cancel_hi_kept: got %h expected 00000000", bus.hi); end
        checks++; if (bus.lo !== 32'd143) begin failures++; $display("FAIL cancel_lo_kept: got %h expected 0000008f", bus.lo); end
    endtask

    // Asynchronous reset between clock edges in the middle of CALC.
    task automatic test_async_reset();
        logic [31:0] h, l;
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.rs_val = 32'd9; bus.rt_val = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (12) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL areset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL areset_done: got %b expected 0", bus.done); end
        checks++; if (bus.hi !== 32'h0) begin failures++; $display("FAIL areset_hi: got %h expected 00000000", bus.hi); end
        checks++; if (bus.lo !== 32'h0) begin failures++; $display("FAIL areset_lo: got %h expected 00000000", bus.lo); end
        @(negedge clk);
        reset = 1'b1;
        run_op(2'b01, 32'd3, 32'd3, h, l, lat);
        checks++; if (l !== 32'd9) begin failures++; $display("FAIL areset_after_lo: got %h expected 00000009", l); end
        checks++; if (h !== 32'd0) begin failures++; $display("FAIL areset_after_hi: got %h expected 00000000", h); end
        checks++; if (lat !== LAT_EXP) begin failures++; $display("FAIL areset_after_lat: got %0d expected %0d", lat, LAT_EXP); end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.rs_val = '0;
        bus.rt_val = '0;
        bus.cancel = 1'b0;
        test_reset();
        test_latency();
        test_arith();
        test_start_while_busy();
        test_cancel();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
